// File: rtl/timer_display_pkg.sv
// Shared timer constants: FSM encodings, segment patterns, BCD helpers.
// Used by the countdown timer display and its seven-segment decoders.
package timer_display_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CONV = 2'd1;
  localparam logic [1:0] ST_LOAD = 2'd2;

  localparam logic [6:0] SEG_0   = 7'b1000000;
  localparam logic [6:0] SEG_1   = 7'b1111001;
  localparam logic [6:0] SEG_2   = 7'b0100100;
  localparam logic [6:0] SEG_3   = 7'b0110000;
  localparam logic [6:0] SEG_4   = 7'b0011001;
  localparam logic [6:0] SEG_5   = 7'b0010010;
  localparam logic [6:0] SEG_6   = 7'b0000010;
  localparam logic [6:0] SEG_7   = 7'b1111000;
  localparam logic [6:0] SEG_8   = 7'b0000000;
  localparam logic [6:0] SEG_9   = 7'b0010000;
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  localparam logic [5:0] MAX_VAL    = 6'd59;
  localparam int         CONV_STEPS = 6;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd2_t;

  function automatic logic [5:0] clamp59(
    input logic [5:0] v
  );
    return (v > MAX_VAL) ? MAX_VAL : v;
  endfunction

  // One double-dabble step: add 3 to any digit >= 5,
  // then shift left pulling in the next binary bit.
  function automatic bcd2_t dabble_step(
    input bcd2_t bcd,
    input logic  bit_in
  );
    bcd2_t adj;
    adj = bcd;
    if (adj.ones >= 4'd5) adj.ones = adj.ones + 4'd3;
    if (adj.tens >= 4'd5) adj.tens = adj.tens + 4'd3;
    return bcd2_t'({adj[6:0], bit_in});
  endfunction

endpackage

// File: rtl/timer_display_seg7_decode.sv
// seg7_decode: 4-bit BCD digit to active-low {g,f,e,d,c,b,a} pattern.
// Ports: bcd (in, 4b), seg (out, 7b); codes 10-15 blank the digit.
module seg7_decode
  import timer_display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    unique case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/timer_display.sv
// MM:SS seven-segment driver: converts min/sec to BCD on change, blinks at end.
// Ports: clock, reset (sync, active-low), min_in, sec_in, timer_end, hex3..hex0, busy.
module timer_display
  import timer_display_pkg::*;
#(
  parameter int CLK_F    = 50000000,
  parameter int BLINK_HZ = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] min_in,
  input  logic [5:0] sec_in,
  input  logic       timer_end,
  output logic [6:0] hex3,
  output logic [6:0] hex2,
  output logic [6:0] hex1,
  output logic [6:0] hex0,
  output logic       busy
);

  localparam int HALF = CLK_F / (2 * BLINK_HZ);
  localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [2:0]    STEP_LAST = 3'(CONV_STEPS - 1);

  logic [1:0]    state_q,   state_d;
  logic [5:0]    sh_min_q,  sh_min_d;
  logic [5:0]    sh_sec_q,  sh_sec_d;
  logic [5:0]    bin_min_q, bin_min_d;
  logic [5:0]    bin_sec_q, bin_sec_d;
  bcd2_t         bcd_min_q, bcd_min_d;
  bcd2_t         bcd_sec_q, bcd_sec_d;
  logic [2:0]    step_q,    step_d;
  bcd2_t         dig_min_q, dig_min_d;
  bcd2_t         dig_sec_q, dig_sec_d;
  logic          busy_q,    busy_d;
  logic [CW-1:0] blink_q,   blink_d;
  logic          blank_q,   blank_d;

  logic          changed;
  logic          blank_on;
  logic [6:0]    seg3, seg2, seg1, seg0;

  assign changed = (min_in != sh_min_q) ||
                   (sec_in != sh_sec_q);

  always_comb begin
    state_d   = state_q;
    sh_min_d  = sh_min_q;
    sh_sec_d  = sh_sec_q;
    bin_min_d = bin_min_q;
    bin_sec_d = bin_sec_q;
    bcd_min_d = bcd_min_q;
    bcd_sec_d = bcd_sec_q;
    step_d    = step_q;
    dig_min_d = dig_min_q;
    dig_sec_d = dig_sec_q;
    unique case (state_q)
      ST_IDLE: begin
        if (changed) begin
          // Shadow keeps raw inputs so a change
          // between two clamped values still reconverts.
          state_d   = ST_CONV;
          sh_min_d  = min_in;
          sh_sec_d  = sec_in;
          bin_min_d = clamp59(min_in);
          bin_sec_d = clamp59(sec_in);
          bcd_min_d = '0;
          bcd_sec_d = '0;
          step_d    = '0;
        end
      end
      ST_CONV: begin
        bcd_min_d = dabble_step(bcd_min_q, bin_min_q[5]);
        bcd_sec_d = dabble_step(bcd_sec_q, bin_sec_q[5]);
        bin_min_d = bin_min_q << 1;
        bin_sec_d = bin_sec_q << 1;
        step_d    = step_q + 3'd1;
        if (step_q == STEP_LAST) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        dig_min_d = bcd_min_q;
        dig_sec_d = bcd_sec_q;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy_d = (state_d != ST_IDLE);

  // Blink phase starts visible: the first toggle
  // comes only after a full half-period.
  always_comb begin
    blink_d = blink_q;
    blank_d = blank_q;
    if (!timer_end) begin
      blink_d = '0;
      blank_d = 1'b0;
    end else if (blink_q == HALF_LAST) begin
      blink_d = '0;
      blank_d = ~blank_q;
    end else begin
      blink_d = blink_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      sh_min_q  <= '0;
      sh_sec_q  <= '0;
      bin_min_q <= '0;
      bin_sec_q <= '0;
      bcd_min_q <= '0;
      bcd_sec_q <= '0;
      step_q    <= '0;
      dig_min_q <= '0;
      dig_sec_q <= '0;
      busy_q    <= 1'b0;
      blink_q   <= '0;
      blank_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sh_min_q  <= sh_min_d;
      sh_sec_q  <= sh_sec_d;
      bin_min_q <= bin_min_d;
      bin_sec_q <= bin_sec_d;
      bcd_min_q <= bcd_min_d;
      bcd_sec_q <= bcd_sec_d;
      step_q    <= step_d;
      dig_min_q <= dig_min_d;
      dig_sec_q <= dig_sec_d;
      busy_q    <= busy_d;
      blink_q   <= blink_d;
      blank_q   <= blank_d;
    end
  end

  seg7_decode u_dec3 (.bcd(dig_min_q.tens), .seg(seg3));
  seg7_decode u_dec2 (.bcd(dig_min_q.ones), .seg(seg2));
  seg7_decode u_dec1 (.bcd(dig_sec_q.tens), .seg(seg1));
  seg7_decode u_dec0 (.bcd(dig_sec_q.ones), .seg(seg0));

  assign blank_on = timer_end & blank_q;

  assign hex3 = blank_on ? SEG_OFF : seg3;
  assign hex2 = blank_on ? SEG_OFF : seg2;
  assign hex1 = blank_on ? SEG_OFF : seg1;
  assign hex0 = blank_on ? SEG_OFF : seg0;
  assign busy = busy_q;

endmodule
